mesa_lb_master: RTL and testbench
=================================

# mesa_lb_master

Local-bus initiator that turns single-word local-bus read/write requests into MesaBus byte packets for a downstream slot. On reads it parses the returned read-response packet back into a 32-bit word. It sits on the upstream side of a `mesa_phy` byte interface (`mesa_wo_byte_*` / `mesa_ri` path). It is the requesting end of the same link that `mesa_core` answers as responder.

## Interface
Parameters:
- `slot`, 8'h00: destination slot byte placed in every request.
- `subslot`, 4'h0: destination subslot nibble.
- `timeout_cyc`, 16'd50000: read-response timeout in `clk` cycles. Used only with `MESA_LB_MASTER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: local-bus clock (`clk_lb_tree` domain).
- `reset`, in, 1: synchronous, active-high.
- `lb_wr`, in, 1: write request pulse; sampled only when `lb_busy`=0.
- `lb_rd`, in, 1: read request pulse; sampled only when `lb_busy`=0.
- `lb_addr`, in, 32: request address.
- `lb_wr_d`, in, 32: write data.
- `lb_busy`, out, 1: transaction in progress.
- `lb_rd_d`, out, 32: read data; valid while `lb_rd_rdy`=1.
- `lb_rd_rdy`, out, 1: one-cycle pulse when a read completes.
- `lb_err`, out, 1: one-cycle pulse on timeout or malformed response.
- `tx_byte_d`, out, 8: byte to the phy.
- `tx_byte_en`, out, 1: one-cycle byte strobe.
- `tx_busy`, in, 1: phy serializer busy.
- `rx_byte_d`, in, 8: byte received from the phy.
- `rx_byte_en`, in, 1: one-cycle received-byte strobe.

## Operation
Request packet, bytes sent in order:
- Header: 0xF0, `slot`, {`subslot`, cmd}, len. cmd=4'h0 is write, 4'h1 is read.
- Write: len=0x08, then `lb_addr` (4 bytes, MSB first), then `lb_wr_d` (4 bytes, MSB first). Total 12 bytes.
- Read: len=0x04, then `lb_addr` (4 bytes, MSB first). Total 8 bytes.

Read response expected: 0xF0, 0xFE, 0x00, 0x04, then 4 data bytes MSB first.

States:
- IDLE: if `lb_wr` or `lb_rd`, latch addr/data/cmd and go to TX. If both are asserted in the same cycle, write wins and the read is dropped.
- TX: 4-bit byte index 0..len+3. A byte may be issued only when `tx_busy`=0 and `tx_byte_en` was 0 in the previous cycle, giving a minimum 2-cycle spacing.
  - After the last byte: write → IDLE; read → RXH.
- RXH: match the 4 header bytes in sequence.
  - 0xF0 at index 0 is required; any other byte at index 0 is ignored (resynchronization).
  - A mismatch at index 1–3 raises `lb_err` and goes to IDLE.
- RXD: shift in 4 bytes. On the 4th byte, load `lb_rd_d`, pulse `lb_rd_rdy`, go to IDLE.
- `rx_byte_en` in IDLE or TX is discarded.
- `lb_busy` = (state != IDLE).
- `lb_wr`/`lb_rd` while `lb_busy`=1 are ignored with no queueing.

Reset values: state=IDLE, `lb_busy`=0, `lb_rd_rdy`=0, `lb_err`=0, `tx_byte_en`=0, `tx_byte_d`=8'h00, `lb_rd_d`=32'h0.
- Reset mid-packet aborts immediately; no further bytes are sent.
- `lb_rd_d` holds its last value until the next completed read.

## Timing
- Request sampled at edge N gives `lb_busy`=1 at N+1; the first `tx_byte_en` comes no earlier than N+1.
- The write path ends in IDLE the cycle after the 12th strobe.
- `lb_rd_rdy` asserts the cycle after the 4th data `rx_byte_en`.
- `lb_busy` falls in that same cycle. A new request is accepted the following cycle.
- `lb_rd_rdy` and `lb_err` never assert together.

## Configuration
- `MESA_LB_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to RXH and on every `rx_byte_en`.
  - When it reaches `timeout_cyc` in RXH or RXD, pulse `lb_err` and go to IDLE.
- Undefined: no counter; the block waits indefinitely for the response. Only `reset` recovers a lost response.

## Test plan
- Write: `lb_wr`, addr=0x00000010, data=0xDEADBEEF, `tx_busy` held 0 → bytes F0 00 00 08 00 00 00 10 DE AD BE EF; `lb_busy` falls after the last byte; no `lb_rd_rdy`.
- Read: `lb_rd`, addr=0x00000020; after 8 TX bytes feed F0 FE 00 04 12 34 56 78 → one-cycle `lb_rd_rdy` with `lb_rd_d`=0x12345678.
- Backpressure: `tx_busy`=1 for 20 cycles after every strobe → byte order unchanged; no strobe while `tx_busy`=1.
- Bad header: read answered with F0 FD → `lb_err` pulse, `lb_busy`=0. Leading garbage 0x55 before F0 is skipped and the read completes.
- Timeout (macro defined, `timeout_cyc`=100): read with no response → `lb_err` exactly 100 cycles after the last TX byte. With the macro undefined, `lb_busy` stays 1.
- Reset after the 5th TX byte of a write → no further strobes, all outputs at reset values; the next `lb_rd` runs normally.

Source files
------------

// File: rtl/mesa_lb_master.sv
// MesaBus local-bus initiator: serializes single-word read/write requests into
// byte packets and parses the read-response packet. Optional macro: MESA_LB_MASTER_TIMEOUT_EN.
module mesa_lb_master #(
  parameter logic [7:0]  slot        = 8'h00,
  parameter logic [3:0]  subslot     = 4'h0,
  parameter logic [15:0] timeout_cyc = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_addr,
  input  logic [31:0] lb_wr_d,
  output logic        lb_busy,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  output logic        lb_err,
  output logic [7:0]  tx_byte_d,
  output logic        tx_byte_en,
  input  logic        tx_busy,
  input  logic [7:0]  rx_byte_d,
  input  logic        rx_byte_en
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RXI_W  = 2;
  localparam int unsigned SH_W   = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RXH, ST_RXD} state_t;

  state_t              state_q, state_nxt;
  logic [WORD_W-1:0]   addr_q, addr_nxt;
  logic [WORD_W-1:0]   wdat_q, wdat_nxt;
  logic                is_rd_q, is_rd_nxt;
  logic [IDX_W-1:0]    tx_idx_q, tx_idx_nxt;
  logic [RXI_W-1:0]    rx_idx_q, rx_idx_nxt;
  logic [SH_W-1:0]     rx_sh_q, rx_sh_nxt;
  logic                lb_busy_nxt, lb_rd_rdy_nxt, lb_err_nxt, tx_byte_en_nxt;
  logic [WORD_W-1:0]   lb_rd_d_nxt;
  logic [BYTE_W-1:0]   tx_byte_d_nxt;
  logic [BYTE_W-1:0]   tx_byte_c;
  logic [BYTE_W-1:0]   hdr_byte_c;
  logic [IDX_W-1:0]    n_bytes_c;

`ifdef MESA_LB_MASTER_TIMEOUT_EN
  logic [15:0]         to_cnt_q, to_cnt_nxt;
  logic                to_hit_c;
  // Counter starts the cycle after the last strobe and lb_err is registered,
  // so firing two counts early lands the pulse timeout_cyc cycles after it.
  assign to_hit_c = (to_cnt_q == 16'(timeout_cyc - 16'd2));
`else
  logic                unused_timeout;
  assign unused_timeout = ^timeout_cyc;
`endif

  // Outgoing packet byte selected by the current index
  always_comb begin
    tx_byte_c = 8'h00;
    n_bytes_c = is_rd_q ? 4'd8 : 4'd12;
    case (tx_idx_q)
      4'd0:    tx_byte_c = 8'hF0;
      4'd1:    tx_byte_c = slot;
      4'd2:    tx_byte_c = {subslot, 3'b000, is_rd_q};
      4'd3:    tx_byte_c = is_rd_q ? 8'h04 : 8'h08;
      4'd4:    tx_byte_c = addr_q[31:24];
      4'd5:    tx_byte_c = addr_q[23:16];
      4'd6:    tx_byte_c = addr_q[15:8];
      4'd7:    tx_byte_c = addr_q[7:0];
      4'd8:    tx_byte_c = wdat_q[31:24];
      4'd9:    tx_byte_c = wdat_q[23:16];
      4'd10:   tx_byte_c = wdat_q[15:8];
      4'd11:   tx_byte_c = wdat_q[7:0];
      default: tx_byte_c = 8'h00;
    endcase
    case (rx_idx_q)
      2'd0:    hdr_byte_c = 8'hF0;
      2'd1:    hdr_byte_c = 8'hFE;
      2'd2:    hdr_byte_c = 8'h00;
      default: hdr_byte_c = 8'h04;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state_q;
    addr_nxt       = addr_q;
    wdat_nxt       = wdat_q;
    is_rd_nxt      = is_rd_q;
    tx_idx_nxt     = tx_idx_q;
    rx_idx_nxt     = rx_idx_q;
    rx_sh_nxt      = rx_sh_q;
    tx_byte_en_nxt = 1'b0;
    tx_byte_d_nxt  = tx_byte_d;
    lb_rd_rdy_nxt  = 1'b0;
    lb_err_nxt     = 1'b0;
    lb_rd_d_nxt    = lb_rd_d;
`ifdef MESA_LB_MASTER_TIMEOUT_EN
    to_cnt_nxt     = to_cnt_q + 16'd1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (lb_wr || lb_rd) begin
          addr_nxt   = lb_addr;
          wdat_nxt   = lb_wr_d;
          is_rd_nxt  = !lb_wr;
          tx_idx_nxt = 4'd0;
          state_nxt  = ST_TX;
        end
      end
      ST_TX: begin
`ifdef MESA_LB_MASTER_TIMEOUT_EN
        to_cnt_nxt = 16'd0;
`endif
        if (tx_idx_q == n_bytes_c) begin
          rx_idx_nxt = 2'd0;
          state_nxt  = is_rd_q ? ST_RXH : ST_IDLE;
        end else if (!tx_busy && !tx_byte_en) begin
          tx_byte_en_nxt = 1'b1;
          tx_byte_d_nxt  = tx_byte_c;
          tx_idx_nxt     = tx_idx_q + 4'd1;
        end
      end
      ST_RXH: begin
        if (rx_byte_en) begin
`ifdef MESA_LB_MASTER_TIMEOUT_EN
          to_cnt_nxt = 16'd0;
`endif
          if (rx_idx_q == 2'd0) begin
            // Anything before the sync byte is skipped
            if (rx_byte_d == 8'hF0) rx_idx_nxt = 2'd1;
          end else if (rx_byte_d == hdr_byte_c) begin
            rx_idx_nxt = rx_idx_q + 2'd1;
            if (rx_idx_q == 2'd3) state_nxt = ST_RXD;
          end else begin
            lb_err_nxt = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
      end
      ST_RXD: begin
        if (rx_byte_en) begin
`ifdef MESA_LB_MASTER_TIMEOUT_EN
          to_cnt_nxt = 16'd0;
`endif
          rx_sh_nxt  = {rx_sh_q[15:0], rx_byte_d};
          rx_idx_nxt = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'd3) begin
            lb_rd_d_nxt   = {rx_sh_q, rx_byte_d};
            lb_rd_rdy_nxt = 1'b1;
            state_nxt     = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

`ifdef MESA_LB_MASTER_TIMEOUT_EN
    if ((state_q == ST_RXH || state_q == ST_RXD) && !rx_byte_en && to_hit_c) begin
      lb_err_nxt = 1'b1;
      state_nxt  = ST_IDLE;
    end
`endif

    lb_busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      is_rd_q    <= 1'b0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      lb_busy    <= 1'b0;
      lb_rd_rdy  <= 1'b0;
      lb_err     <= 1'b0;
      lb_rd_d    <= '0;
      tx_byte_en <= 1'b0;
      tx_byte_d  <= '0;
`ifdef MESA_LB_MASTER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_nxt;
      wdat_q     <= wdat_nxt;
      is_rd_q    <= is_rd_nxt;
      tx_idx_q   <= tx_idx_nxt;
      rx_idx_q   <= rx_idx_nxt;
      rx_sh_q    <= rx_sh_nxt;
      lb_busy    <= lb_busy_nxt;
      lb_rd_rdy  <= lb_rd_rdy_nxt;
      lb_err     <= lb_err_nxt;
      lb_rd_d    <= lb_rd_d_nxt;
      tx_byte_en <= tx_byte_en_nxt;
      tx_byte_d  <= tx_byte_d_nxt;
`ifdef MESA_LB_MASTER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mesa_lb_master.sv
// Self-checking bench for mesa_lb_master: randomized requests against a packet-level
// reference model, plus directed header, timeout and reset cases.
module tb_mesa_lb_master;

  localparam logic [7:0]  SLOT    = 8'h00;
  localparam logic [3:0]  SUBSLOT = 4'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lb_wr = 1'b0, lb_rd = 1'b0;
  logic [31:0] lb_addr = '0, lb_wr_d = '0;
  logic        lb_busy;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy, lb_err;
  logic [7:0]  tx_byte_d;
  logic        tx_byte_en;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_byte_d = '0;
  logic        rx_byte_en = 1'b0;

  mesa_lb_master #(.slot(SLOT), .subslot(SUBSLOT), .timeout_cyc(16'd100)) dut (
    .clk(clk), .reset(reset), .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr),
    .lb_wr_d(lb_wr_d), .lb_busy(lb_busy), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
    .lb_err(lb_err), .tx_byte_d(tx_byte_d), .tx_byte_en(tx_byte_en), .tx_busy(tx_busy),
    .rx_byte_d(rx_byte_d), .rx_byte_en(rx_byte_en));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Observed-traffic monitor and phy backpressure model
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int  rdy_cnt = 0, err_cnt = 0, both_cnt = 0, bp_viol = 0, gap_viol = 0;
  bit  prev_en = 1'b0;
  bit  bp_en = 1'b0;
  int  bp_left = 0;

  always @(posedge clk) begin
    #1;
    if (tx_byte_en) begin
      tx_q.push_back(tx_byte_d);
      if (tx_busy) bp_viol++;
      if (prev_en) gap_viol++;
      if (bp_en) bp_left = 20;
    end
    prev_en = tx_byte_en;
    if (lb_rd_rdy) rdy_cnt++;
    if (lb_err) err_cnt++;
    if (lb_rd_rdy && lb_err) both_cnt++;
  end

  always @(negedge clk) begin
    tx_busy = (bp_left != 0);
    if (bp_left != 0) bp_left--;
  end

  // Reference packet built from the request fields
  task automatic build_req(input bit rd, input logic [31:0] a, input logic [31:0] d);
    exp_q.delete();
    exp_q.push_back(8'hF0);
    exp_q.push_back(SLOT);
    exp_q.push_back({SUBSLOT, rd ? 4'h1 : 4'h0});
    exp_q.push_back(rd ? 8'h04 : 8'h08);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
    if (!rd) for (int i = 3; i >= 0; i--) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    lb_wr = wr; lb_rd = rd; lb_addr = a; lb_wr_d = d;
    @(negedge clk);
    lb_wr = 1'b0; lb_rd = 1'b0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      if (tx_q.size() >= n) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_tx: got %0d bytes want %0d", tx_q.size(), n); end
  endtask

  task automatic check_tx(input string name);
    total++;
    if (tx_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL %s_len: got %0d want %0d", name, tx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      total++;
      if (tx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_byte%0d: got %h want %h", name, i, tx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte_d = b; rx_byte_en = 1'b1;
    @(negedge clk);
    rx_byte_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string name);
    bit ok;
    int r0;
    r0 = rdy_cnt;
    tx_q.delete();
    build_req(1'b0, a, d);
    issue(1'b1, 1'b0, a, d);
    total++;
    if (lb_busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise: got %b want 1", name, lb_busy); end
    wait_tx(12, ok);
    total++;
    if (lb_busy !== 1'b1) begin bad++; $display("FAIL %s_busy_last: got %b want 1", name, lb_busy); end
    @(posedge clk); #2;
    total++;
    if (lb_busy !== 1'b0) begin bad++; $display("FAIL %s_busy_fall: got %b want 0", name, lb_busy); end
    check_tx(name);
    total++;
    if (rdy_cnt !== r0) begin bad++; $display("FAIL %s_no_rdy: got %0d want %0d", name, rdy_cnt, r0); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] w, input bit garbage,
                         input string name);
    bit ok;
    int r0;
    logic [7:0] g;
    r0 = rdy_cnt;
    tx_q.delete();
    build_req(1'b1, a, 32'h0);
    issue(1'b0, 1'b1, a, 32'h0);
    wait_tx(8, ok);
    check_tx(name);
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
    if (garbage) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hF0) g = 8'h55;
      send_rx(g);
    end
    send_rx(8'hF0); send_rx(8'hFE); send_rx(8'h00); send_rx(8'h04);
    for (int i = 3; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rx(8'((w >> (8 * i)) & 32'hFF));
    end
    #1;
    total++;
    if (lb_rd_rdy !== 1'b1) begin bad++; $display("FAIL %s_rdy: got %b want 1", name, lb_rd_rdy); end
    total++;
    if (lb_rd_d !== w) begin bad++; $display("FAIL %s_data: got %h want %h", name, lb_rd_d, w); end
    total++;
    if (lb_busy !== 1'b0 || lb_err !== 1'b0) begin
      bad++; $display("FAIL %s_busy_err: got %b%b want 00", name, lb_busy, lb_err);
    end
    @(posedge clk); #2;
    total++;
    if (lb_rd_rdy !== 1'b0 || rdy_cnt !== r0 + 1) begin
      bad++; $display("FAIL %s_pulse: got rdy=%b cnt=%0d want 0 %0d", name, lb_rd_rdy, rdy_cnt, r0 + 1);
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({lb_busy, lb_rd_rdy, lb_err, tx_byte_en} !== 4'b0000 || tx_byte_d !== 8'h00 ||
        lb_rd_d !== 32'h0) begin
      bad++;
      $display("FAIL %s: got busy=%b rdy=%b err=%b en=%b d=%h rd_d=%h want all zero",
               name, lb_busy, lb_rd_rdy, lb_err, tx_byte_en, tx_byte_d, lb_rd_d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset_vals");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    check_reset_vals("post_reset_idle");
  endtask

  task automatic test_write();
    do_write(32'h0000_0010, 32'hDEAD_BEEF, "write_dir");
  endtask

  task automatic test_read();
    do_read(32'h0000_0020, 32'h1234_5678, 1'b0, "read_dir");
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    do_write(32'hA5A5_0F0F, 32'h0102_0304, "bp_write");
    do_read(32'h7700_0044, 32'hCAFE_F00D, 1'b0, "bp_read");
    bp_en = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_random_txn();
    for (int n = 0; n < 8; n++) begin
      bp_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, "rnd_write");
      else
        do_read($urandom, $urandom, $urandom_range(0, 1) == 1, "rnd_read");
      bp_en = 1'b0;
      repeat (22) @(negedge clk);
    end
  endtask

  task automatic test_garbage_skip();
    do_read(32'h0000_0030, 32'h8765_4321, 1'b1, "garbage_read");
  endtask

  task automatic test_bad_header();
    bit ok;
    int r0;
    r0 = rdy_cnt;
    tx_q.delete();
    issue(1'b0, 1'b1, 32'h0000_0040, 32'h0);
    wait_tx(8, ok);
    repeat (2) @(negedge clk);
    send_rx(8'hF0);
    send_rx(8'hFD);
    #1;
    total++;
    if (lb_err !== 1'b1 || lb_busy !== 1'b0 || lb_rd_rdy !== 1'b0) begin
      bad++; $display("FAIL bad_hdr: got err=%b busy=%b rdy=%b want 1 0 0", lb_err, lb_busy, lb_rd_rdy);
    end
    @(posedge clk); #2;
    total++;
    if (lb_err !== 1'b0 || rdy_cnt !== r0) begin
      bad++; $display("FAIL bad_hdr_pulse: got err=%b rdy_cnt=%0d want 0 %0d", lb_err, rdy_cnt, r0);
    end
  endtask

  task automatic test_collision_ignore();
    bit ok;
    tx_q.delete();
    build_req(1'b0, 32'h1111_2222, 32'h3333_4444);
    issue(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);
    repeat (3) @(negedge clk);
    lb_rd = 1'b1; lb_wr = 1'b1; lb_addr = 32'h9999_9999;
    @(negedge clk);
    lb_rd = 1'b0; lb_wr = 1'b0;
    wait_tx(12, ok);
    repeat (40) begin @(posedge clk); #2; end
    check_tx("collision");
    total++;
    if (lb_busy !== 1'b0) begin bad++; $display("FAIL collision_idle: got %b want 0", lb_busy); end
  endtask

  task automatic test_rx_in_idle();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_rx(8'hF0); send_rx(8'hFE); send_rx(8'h00); send_rx(8'h04);
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    @(posedge clk); #2;
    total++;
    if (rdy_cnt !== r0 || err_cnt !== e0 || lb_busy !== 1'b0) begin
      bad++; $display("FAIL rx_idle: got rdy=%0d err=%0d busy=%b want %0d %0d 0",
                      rdy_cnt, err_cnt, lb_busy, r0, e0);
    end
    do_read(32'h0000_0050, 32'h0BAD_F00D, 1'b0, "after_idle_rx");
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    int e0;
    e0 = err_cnt;
    tx_q.delete();
    issue(1'b0, 1'b1, 32'h0000_0060, 32'h0);
    wait_tx(8, ok);
`ifdef MESA_LB_MASTER_TIMEOUT_EN
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #2;
      if (lb_err) begin k = c; break; end
    end
    total++;
    if (k !== 100) begin bad++; $display("FAIL timeout_cyc: got %0d want 100", k); end
    total++;
    if (lb_busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: got %b want 0", lb_busy); end
`else
    k = 0;
    repeat (300) begin @(posedge clk); #2; end
    total++;
    if (lb_busy !== 1'b1 || err_cnt !== e0) begin
      bad++; $display("FAIL no_timeout: got busy=%b err=%0d want 1 %0d", lb_busy, err_cnt, e0);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    total++;
    if (lb_busy !== 1'b0) begin bad++; $display("FAIL no_timeout_reset: got %b want 0", lb_busy); end
`endif
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    tx_q.delete();
    issue(1'b1, 1'b0, 32'hFEDC_BA98, 32'h7654_3210);
    wait_tx(5, ok);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    check_reset_vals("mid_reset_vals");
    @(negedge clk); reset = 1'b0;
    repeat (30) begin @(posedge clk); #2; end
    total++;
    if (tx_q.size() !== 5 || lb_busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_abort: got %0d bytes busy=%b want 5 0", tx_q.size(), lb_busy);
    end
    do_read(32'h0000_0070, 32'h5A5A_A5A5, 1'b0, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_random_txn();
    test_garbage_skip();
    test_bad_header();
    test_collision_ignore();
    test_rx_in_idle();
    test_timeout();
    test_reset_mid_packet();
    total++;
    if (bp_viol !== 0 || gap_viol !== 0) begin
      bad++; $display("FAIL strobe_rules: got bp=%0d gap=%0d want 0 0", bp_viol, gap_viol);
    end
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL rdy_err_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
